i2c_master_transfer_sequencer: RTL

Byte-level transfer controller for the I2C master datapath. It accepts one transfer descriptor: 7-bit slave address, register address, read/write, and byte count. It then sequences START / address / register / data / RESTART / STOP commands into the downstream bit-level engine. Write data streams in and read data streams out, one byte per handshake. It reports completion with ACK/NACK status.

---
 rtl/i2c_master_transfer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_transfer_sequencer.sv
// Byte-level I2C transfer sequencer: turns one transfer descriptor into a
// START/address/register/data/RESTART/STOP command stream for the bit engine.
module i2c_master_transfer_sequencer #(
   parameter int SLAVE_ADDRESS_WIDTH    = 7,
   parameter int REGISTER_ADDRESS_WIDTH = 8,
   parameter int DATA_LENGTH            = 8,
   parameter int MAX_BYTES              = 128,
   parameter int LEN_W                  = $clog2(MAX_BYTES + 1)
) (
   input  logic                              pclk,
   input  logic                              areset,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [SLAVE_ADDRESS_WIDTH-1:0]    req_slave_addr,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] req_reg_addr,
   input  logic                              req_rw,
   input  logic [LEN_W-1:0]                  req_len,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [DATA_LENGTH-1:0]            wr_data,
   output logic                              rd_valid,
   output logic [DATA_LENGTH-1:0]            rd_data,
   output logic                              rd_last,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output logic [2:0]                        cmd_op,
   output logic [DATA_LENGTH-1:0]            cmd_wdata,
   output logic                              cmd_master_ack,
   input  logic                              rsp_valid,
   input  logic [DATA_LENGTH-1:0]            rsp_rdata,
   input  logic                              rsp_slave_nack,
   output logic                              done,
   output logic                              done_nack,
   output logic                              busy
);

   localparam logic [2:0] OP_START   = 3'd0;
   localparam logic [2:0] OP_RESTART = 3'd1;
   localparam logic [2:0] OP_WRITE   = 3'd2;
   localparam logic [2:0] OP_READ    = 3'd3;
   localparam logic [2:0] OP_STOP    = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_START   = 4'd1,
      ST_ADDR_W  = 4'd2,
      ST_REG     = 4'd3,
      ST_DATA_W  = 4'd4,
      ST_RESTART = 4'd5,
      ST_ADDR_R  = 4'd6,
      ST_DATA_R  = 4'd7,
      ST_STOP    = 4'd8,
      ST_DONE    = 4'd9
   } state_t;

   // Bit-engine opcode carried by each command-issuing state.
   function automatic logic [2:0] op_of(input state_t st);
      logic [2:0] op;
      case (st)
         ST_START:   op = OP_START;
         ST_RESTART: op = OP_RESTART;
         ST_ADDR_W:  op = OP_WRITE;
         ST_REG:     op = OP_WRITE;
         ST_DATA_W:  op = OP_WRITE;
         ST_ADDR_R:  op = OP_WRITE;
         ST_DATA_R:  op = OP_READ;
         ST_STOP:    op = OP_STOP;
         default:    op = OP_START;
      endcase
      return op;
   endfunction

   state_t                            state_r, state_s;
   logic                              wait_r, wait_s;
   logic                              held_r, held_s;
   logic [DATA_LENGTH-1:0]            byte_r, byte_s;
   logic [LEN_W-1:0]                  cnt_r, cnt_s;
   logic [SLAVE_ADDRESS_WIDTH-1:0]    slave_r, slave_s;
   logic [REGISTER_ADDRESS_WIDTH-1:0] reg_r, reg_s;
   logic                              rw_r, rw_s;
   logic                              len_bad_r, len_bad_s;
   logic                              nack_r, nack_s;
   logic                              nack_hit_s;

   logic                              req_ready_r, req_ready_s;
   logic                              wr_ready_r, wr_ready_s;
   logic                              rd_valid_r, rd_valid_s;
   logic [DATA_LENGTH-1:0]            rd_data_r, rd_data_s;
   logic                              rd_last_r, rd_last_s;
   logic                              cmd_valid_r, cmd_valid_s;
   logic [2:0]                        cmd_op_r, cmd_op_s;
   logic [DATA_LENGTH-1:0]            cmd_wdata_r, cmd_wdata_s;
   logic                              cmd_master_ack_r, cmd_master_ack_s;
   logic                              done_r, done_s;
   logic                              done_nack_r, done_nack_s;
   logic                              busy_r, busy_s;

   // Next-state, datapath and next-output computation.
   always_comb begin
      state_s    = state_r;
      wait_s     = wait_r;
      held_s     = held_r;
      byte_s     = byte_r;
      cnt_s      = cnt_r;
      slave_s    = slave_r;
      reg_s      = reg_r;
      rw_s       = rw_r;
      len_bad_s  = len_bad_r;
      nack_s     = nack_r;
      nack_hit_s = 1'b0;
      rd_valid_s = 1'b0;
      rd_data_s  = rd_data_r;
      rd_last_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               slave_s   = req_slave_addr;
               reg_s     = req_reg_addr;
               rw_s      = req_rw;
               cnt_s     = req_len;
               len_bad_s = (req_len == {LEN_W{1'b0}}) || (req_len > LEN_W'(MAX_BYTES));
               nack_s    = 1'b0;
               wait_s    = 1'b0;
               held_s    = 1'b0;
               state_s   = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            if (len_bad_r) begin
               // Illegal length: report an aborted transfer without touching the bus.
               nack_s  = 1'b1;
               state_s = ST_DONE;
            end else if (!wait_r) begin
               if ((state_r == ST_DATA_W) && !held_r) begin
                  if (wr_valid && wr_ready_r) begin
                     held_s = 1'b1;
                     byte_s = wr_data;
                  end else begin
                     held_s = 1'b0;
                  end
               end else if (cmd_valid_r && cmd_ready) begin
                  wait_s = 1'b1;
                  held_s = 1'b0;
               end else begin
                  wait_s = 1'b0;
               end
            end else if (rsp_valid) begin
               wait_s     = 1'b0;
               nack_hit_s = rsp_slave_nack && (cmd_op_r == OP_WRITE);
               if (nack_hit_s) begin
                  nack_s = 1'b1;
               end else begin
                  nack_s = nack_r;
               end
               case (state_r)
                  ST_START:   state_s = ST_ADDR_W;
                  ST_ADDR_W:  state_s = nack_hit_s ? ST_STOP : ST_REG;
                  ST_REG: begin
                     if (nack_hit_s) begin
                        state_s = ST_STOP;
                     end else if (rw_r) begin
                        state_s = ST_RESTART;
                     end else begin
                        state_s = ST_DATA_W;
                     end
                  end
                  ST_DATA_W: begin
                     if (nack_hit_s || (cnt_r == LEN_W'(1))) begin
                        state_s = ST_STOP;
                     end else begin
                        cnt_s = cnt_r - LEN_W'(1);
                     end
                  end
                  ST_RESTART: state_s = ST_ADDR_R;
                  ST_ADDR_R:  state_s = nack_hit_s ? ST_STOP : ST_DATA_R;
                  ST_DATA_R: begin
                     rd_valid_s = 1'b1;
                     rd_data_s  = rsp_rdata;
                     rd_last_s  = (cnt_r == LEN_W'(1));
                     if (cnt_r == LEN_W'(1)) begin
                        state_s = ST_STOP;
                     end else begin
                        cnt_s = cnt_r - LEN_W'(1);
                     end
                  end
                  ST_STOP:    state_s = ST_DONE;
                  default:    state_s = ST_IDLE;
               endcase
            end else begin
               wait_s = 1'b1;
            end
         end
      endcase

      // Outputs are decoded from the next state so they leave a register.
      req_ready_s      = (state_s == ST_IDLE);
      busy_s           = (state_s != ST_IDLE);
      done_s           = (state_s == ST_DONE);
      done_nack_s      = (state_s == ST_DONE) && nack_s;
      wr_ready_s       = (state_s == ST_DATA_W) && !wait_s && !held_s;
      cmd_op_s         = op_of(state_s);
      cmd_master_ack_s = (state_s == ST_DATA_R) && (cnt_s == LEN_W'(1));
      if ((state_s == ST_IDLE) || (state_s == ST_DONE) || wait_s || len_bad_s) begin
         cmd_valid_s = 1'b0;
      end else if (state_s == ST_DATA_W) begin
         cmd_valid_s = held_s;
      end else begin
         cmd_valid_s = 1'b1;
      end
      case (state_s)
         ST_ADDR_W: cmd_wdata_s = DATA_LENGTH'({slave_s, 1'b0});
         ST_ADDR_R: cmd_wdata_s = DATA_LENGTH'({slave_s, 1'b1});
         ST_REG:    cmd_wdata_s = DATA_LENGTH'(reg_s);
         ST_DATA_W: cmd_wdata_s = byte_s;
         default:   cmd_wdata_s = {DATA_LENGTH{1'b0}};
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge pclk) begin
      if (!areset) begin
         state_r          <= ST_IDLE;
         wait_r           <= 1'b0;
         held_r           <= 1'b0;
         byte_r           <= {DATA_LENGTH{1'b0}};
         cnt_r            <= {LEN_W{1'b0}};
         slave_r          <= {SLAVE_ADDRESS_WIDTH{1'b0}};
         reg_r            <= {REGISTER_ADDRESS_WIDTH{1'b0}};
         rw_r             <= 1'b0;
         len_bad_r        <= 1'b0;
         nack_r           <= 1'b0;
         req_ready_r      <= 1'b1;
         wr_ready_r       <= 1'b0;
         rd_valid_r       <= 1'b0;
         rd_data_r        <= {DATA_LENGTH{1'b0}};
         rd_last_r        <= 1'b0;
         cmd_valid_r      <= 1'b0;
         cmd_op_r         <= 3'd0;
         cmd_wdata_r      <= {DATA_LENGTH{1'b0}};
         cmd_master_ack_r <= 1'b0;
         done_r           <= 1'b0;
         done_nack_r      <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         state_r          <= state_s;
         wait_r           <= wait_s;
         held_r           <= held_s;
         byte_r           <= byte_s;
         cnt_r            <= cnt_s;
         slave_r          <= slave_s;
         reg_r            <= reg_s;
         rw_r             <= rw_s;
         len_bad_r        <= len_bad_s;
         nack_r           <= nack_s;
         req_ready_r      <= req_ready_s;
         wr_ready_r       <= wr_ready_s;
         rd_valid_r       <= rd_valid_s;
         rd_data_r        <= rd_data_s;
         rd_last_r        <= rd_last_s;
         cmd_valid_r      <= cmd_valid_s;
         cmd_op_r         <= cmd_op_s;
         cmd_wdata_r      <= cmd_wdata_s;
         cmd_master_ack_r <= cmd_master_ack_s;
         done_r           <= done_s;
         done_nack_r      <= done_nack_s;
         busy_r           <= busy_s;
      end
   end

   assign req_ready      = req_ready_r;
   assign wr_ready       = wr_ready_r;
   assign rd_valid       = rd_valid_r;
   assign rd_data        = rd_data_r;
   assign rd_last        = rd_last_r;
   assign cmd_valid      = cmd_valid_r;
   assign cmd_op         = cmd_op_r;
   assign cmd_wdata      = cmd_wdata_r;
   assign cmd_master_ack = cmd_master_ack_r;
   assign done           = done_r;
   assign done_nack      = done_nack_r;
   assign busy           = busy_r;

endmodule
